// File: rtl/mips_pkg.sv
// Shared definitions for the register-file writeback path: field widths,
// the writeback arbiter state encoding and a register one-hot decoder.
package mips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  // Occupancy of the two writeback buffers plus, when both hold an entry,
  // which one was accepted first.
  typedef enum logic [2:0] {
    EMPTY,
    A_ONLY,
    B_ONLY,
    BOTH_A_OLD,
    BOTH_B_OLD
  } arb_state_e;

  // One-hot decode of a register number into a register-file-wide mask.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    logic [NREGS-1:0] m;
    m = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_slot.sv
// Single-entry writeback buffer: holds one (reg, data) pair until drained.
module wb_slot
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [REG_W-1:0]  load_reg,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [REG_W-1:0]  slot_reg,
  output logic [DATA_W-1:0] slot_data
);

  // Occupancy flag: a load wins over a drain so the slot can refill in the
  // same cycle it is written back.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every flop so all state updates
    // see the pre-edge values regardless of block ordering.
    if (rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // Payload capture on load.
  always_ff @(posedge clk) begin
    // NOTE: the payload is deliberately not reset; it is only ever observed
    // when valid is set, so clearing it would just cost reset fan-out.
    if (load) begin
      slot_reg  <= load_reg;
      slot_data <= load_data;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two writeback requesters (ALU path A, load/multicycle path B)
// onto the single register-file write port, oldest entry first.
module regfile_write_arbiter
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [REG_W-1:0]  a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [REG_W-1:0]  b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [REG_W-1:0]  wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREGS-1:0]  busy_mask
);

  arb_state_e        state, state_n;
  logic              rr, rr_n;
  logic              grant_a, grant_b;
  logic              a_load, b_load;
  logic              a_keep, b_keep;
  logic              a_occ, b_occ;
  logic [REG_W-1:0]  a_slot_reg, b_slot_reg;
  logic [DATA_W-1:0] a_slot_data, b_slot_data;

  wb_slot u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (a_load),
    .drain     (grant_a),
    .load_reg  (a_reg),
    .load_data (a_data),
    .valid     (a_occ),
    .slot_reg  (a_slot_reg),
    .slot_data (a_slot_data)
  );

  wb_slot u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (b_load),
    .drain     (grant_b),
    .load_reg  (b_reg),
    .load_data (b_data),
    .valid     (b_occ),
    .slot_reg  (b_slot_reg),
    .slot_data (b_slot_data)
  );

  // Handshake: a buffer can take a new entry when empty or when it is being
  // written back this cycle. Requests to r0 are accepted but never buffered.
  assign a_ready = rst | ~a_occ | grant_a;
  assign b_ready = rst | ~b_occ | grant_b;
  assign a_load  = ~rst & a_valid & a_ready & (a_reg != '0);
  assign b_load  = ~rst & b_valid & b_ready & (b_reg != '0);
  assign a_keep  = a_occ & ~grant_a;
  assign b_keep  = b_occ & ~grant_b;

  // FSM state and tie-break pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      rr    <= 1'b0;
    end else begin
      state <= state_n;
      rr    <= rr_n;
    end
  end

  // Grant decode and next-state: older entry first, ties by round-robin.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and no latch is inferred.
    grant_a = 1'b0;
    grant_b = 1'b0;
    state_n = state;
    rr_n    = rr;

    unique case (state)
      A_ONLY, BOTH_A_OLD: grant_a = ~rst;
      B_ONLY, BOTH_B_OLD: grant_b = ~rst;
      default: ;
    endcase

    if (a_load && b_load) begin
      state_n = rr ? BOTH_B_OLD : BOTH_A_OLD;
      rr_n    = ~rr;
    end else if (a_load && b_keep) begin
      state_n = BOTH_B_OLD;
    end else if (b_load && a_keep) begin
      state_n = BOTH_A_OLD;
    end else if (a_keep && b_keep) begin
      state_n = state;
    end else if (a_load || a_keep) begin
      state_n = A_ONLY;
    end else if (b_load || b_keep) begin
      state_n = B_ONLY;
    end else begin
      state_n = EMPTY;
    end
  end

  // Register-file write port, forced to zero when idle.
  always_comb begin
    wr_en   = grant_a | grant_b;
    wr_reg  = '0;
    wr_data = '0;
    if (grant_a) begin
      wr_reg  = a_slot_reg;
      wr_data = a_slot_data;
    end else if (grant_b) begin
      wr_reg  = b_slot_reg;
      wr_data = b_slot_data;
    end
  end

  // Pending-write mask for decode stall logic; r0 is never busy.
  always_comb begin
    busy_mask = '0;
    if (a_occ) busy_mask = busy_mask | reg_onehot(a_slot_reg);
    if (b_occ) busy_mask = busy_mask | reg_onehot(b_slot_reg);
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [31:0] busy_mask;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_reg     (a_reg),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_reg     (b_reg),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s mismatch", tag);
    end
  endtask

  // Advance one clock; leave 1 time unit after the edge before returning.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_port(input string tag);
    check({tag, ".wr_en"},   {31'd0, wr_en}, 32'd0);
    check({tag, ".wr_reg"},  {27'd0, wr_reg}, 32'd0);
    check({tag, ".wr_data"}, wr_data, 32'd0);
    check({tag, ".busy"},    busy_mask, 32'd0);
  endtask

  task automatic write_seen(input string tag, input logic [4:0] r, input logic [31:0] d);
    check({tag, ".wr_en"},   {31'd0, wr_en}, 32'd1);
    check({tag, ".wr_reg"},  {27'd0, wr_reg}, {27'd0, r});
    check({tag, ".wr_data"}, wr_data, d);
  endtask

  initial begin
    int a_i, b_i, n_wr, last_wr;
    logic a_acc, b_acc;
    logic [4:0]  exp_r;
    logic [31:0] exp_d;

    // Reset held two cycles while A presents a request.
    rst = 1'b1;
    a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h1234_5678;
    b_valid = 1'b0; b_reg = 5'd0; b_data = 32'd0;
    tick();
    idle_port("rst1");
    check("rst1.a_ready", {31'd0, a_ready}, 32'd1);
    check("rst1.b_ready", {31'd0, b_ready}, 32'd1);
    tick();
    idle_port("rst2");
    rst = 1'b0;
    a_valid = 1'b0;
    #1;
    idle_port("post_rst");
    check("post_rst.a_ready", {31'd0, a_ready}, 32'd1);
    check("post_rst.b_ready", {31'd0, b_ready}, 32'd1);

    // Single write from A.
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEAD_BEEF;
    tick();
    a_valid = 1'b0;
    write_seen("single", 5'd5, 32'hDEAD_BEEF);
    check("single.busy", busy_mask, 32'h0000_0020);
    tick();
    idle_port("single.after");

    // Tie on r3 with rr = 0: A first, then B.
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_reg = 5'd3; b_data = 32'h22;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    write_seen("tie1.first", 5'd3, 32'h11);
    check("tie1.busy", busy_mask, 32'h0000_0008);
    check("tie1.a_ready", {31'd0, a_ready}, 32'd1);
    check("tie1.b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    write_seen("tie1.second", 5'd3, 32'h22);
    tick();
    idle_port("tie1.after");

    // Same tie again: rr has toggled, so B goes first.
    a_valid = 1'b1; b_valid = 1'b1;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    write_seen("tie2.first", 5'd3, 32'h22);
    check("tie2.a_ready", {31'd0, a_ready}, 32'd0);
    tick();
    write_seen("tie2.second", 5'd3, 32'h11);
    tick();
    idle_port("tie2.after");

    // Older-first: B r7, then A r8 the next cycle.
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h0000_0707;
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1; a_reg = 5'd8; a_data = 32'h0000_0808;
    #1;
    check("older.a_ready", {31'd0, a_ready}, 32'd1);
    write_seen("older.first", 5'd7, 32'h0000_0707);
    check("older.busy1", busy_mask, 32'h0000_0080);
    tick();
    a_valid = 1'b0;
    write_seen("older.second", 5'd8, 32'h0000_0808);
    check("older.busy2", busy_mask, 32'h0000_0100);
    tick();
    idle_port("older.after");

    // Writes to r0 are accepted and dropped.
    a_valid = 1'b1; a_reg = 5'd0; a_data = 32'h0000_FFFF;
    #1;
    check("r0.a_ready", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
    idle_port("r0");

    // Reset mid-operation: tie-loaded entries (rr -> 1) are discarded.
    a_valid = 1'b1; a_reg = 5'd12; a_data = 32'hAAAA_0012;
    b_valid = 1'b1; b_reg = 5'd13; b_data = 32'hBBBB_0013;
    tick();
    rst = 1'b1;
    #1;
    check("midrst.wr_en", {31'd0, wr_en}, 32'd0);
    tick();
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    idle_port("midrst.after");

    // Streaming: 10 requests each, valid held until accepted. rr is back to
    // 0, so writes alternate A0, B0, A1, B1, ... over cycles 1..20.
    a_i = 0; b_i = 0; n_wr = 0; last_wr = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      a_valid = (a_i < 10);
      a_reg   = 5'(1 + a_i);
      a_data  = 32'hA000_0000 + 32'(a_i);
      b_valid = (b_i < 10);
      b_reg   = 5'(11 + b_i);
      b_data  = 32'hB000_0000 + 32'(b_i);
      #1;
      a_acc = a_valid & a_ready;
      b_acc = b_valid & b_ready;
      if (wr_en) begin
        if (n_wr % 2 == 0) begin
          exp_r = 5'(1 + n_wr / 2);
          exp_d = 32'hA000_0000 + 32'(n_wr / 2);
        end else begin
          exp_r = 5'(11 + n_wr / 2);
          exp_d = 32'hB000_0000 + 32'(n_wr / 2);
        end
        check($sformatf("stream.w%0d.reg", n_wr), {27'd0, wr_reg}, {27'd0, exp_r});
        check($sformatf("stream.w%0d.data", n_wr), wr_data, exp_d);
        n_wr++;
        last_wr = cyc;
      end
      if (a_i == 10 && b_i == 10 && !wr_en) break;
      tick();
      if (a_acc) a_i++;
      if (b_acc) b_i++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("stream.count", 32'(n_wr), 32'd20);
    check("stream.last_cycle", 32'(last_wr), 32'd20);
    check("stream.a_sent", 32'(a_i), 32'd10);
    check("stream.b_sent", 32'(b_i), 32'd10);
    idle_port("stream.after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
